// File: rtl/aes256_cipher_if.sv
// Start/done handshake and key bus shared by the AES-256 forward and inverse cores.
// err_o exists only when AES_START_ERR_EN is defined.
interface aes256_cipher_if #(
  parameter int KW = 1920
);
  logic          basla_i;
  logic [127:0]  metin_i;
  logic [KW-1:0] key_i;
  logic [127:0]  metin_o;
  logic          bitti_o;
  logic          busy_o;
`ifdef AES_START_ERR_EN
  logic          err_o;
`endif

  modport master (
    output basla_i, metin_i, key_i,
`ifdef AES_START_ERR_EN
    input  err_o,
`endif
    input  metin_o, bitti_o, busy_o
  );

  modport slave (
    input  basla_i, metin_i, key_i,
`ifdef AES_START_ERR_EN
    output err_o,
`endif
    output metin_o, bitti_o, busy_o
  );
endinterface

// File: rtl/aes256_cipher.sv
// Iterative AES-256 encryption core, one round per clock, 15-clock latency.
// Optional AES_START_ERR_EN adds err_o, flagging starts requested while busy.
//
// state | meaning
// IDLE  | waiting for basla_i; initial AddRoundKey on acceptance
// ROUND | full rounds 1..13
// FINAL | round 14 without MixColumns, result to metin_o, done pulse
module aes256_cipher #(
  parameter int NR = 14,
  parameter int KW = 1920
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  aes256_cipher_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_e;

  localparam logic [7:0] SBOX [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = SBOX[s[8*i +: 8]];
    return r;
  endfunction

  // Byte b = row + 4*col sits at bits [127-8b -: 8]; row r rotates left by r columns.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] r;
    for (int row = 0; row < 4; row++)
      for (int col = 0; col < 4; col++)
        r[8*(15-(row+4*col)) +: 8] = s[8*(15-(row+4*((col+row)%4))) +: 8];
    return r;
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   a0, a1, a2, a3;
    for (int col = 0; col < 4; col++) begin
      a0 = s[8*(15-4*col) +: 8];
      a1 = s[8*(14-4*col) +: 8];
      a2 = s[8*(13-4*col) +: 8];
      a3 = s[8*(12-4*col) +: 8];
      r[8*(15-4*col) +: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
      r[8*(14-4*col) +: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
      r[8*(13-4*col) +: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
      r[8*(12-4*col) +: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
    end
    return r;
  endfunction

  state_e        state_q, state_d;
  logic [3:0]    rc_q, rc_d;
  logic [127:0]  st_q, st_d;
  logic [127:0]  out_q, out_d;
  logic          done_q, done_d;
  logic [KW-1:0] key_w;
  logic [3:0]    kidx;
  logic [10:0]   koff;
  logic [127:0]  rk;

  // rc is 0 while idle, so slice 14 (round key 0) is selected at acceptance.
  assign key_w = bus.key_i;
  assign kidx  = 4'(NR) - rc_q;
  assign koff  = {kidx, 7'd0};
  assign rk    = key_w[koff +: 128];

  always_comb begin
    state_d = state_q;
    rc_d    = rc_q;
    st_d    = st_q;
    out_d   = out_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.basla_i) begin
          st_d    = bus.metin_i ^ rk;
          rc_d    = 4'd1;
          state_d = ROUND;
        end
      end
      ROUND: begin
        st_d = mix_columns(shift_rows(sub_bytes(st_q))) ^ rk;
        rc_d = rc_q + 4'd1;
        if (rc_q == 4'(NR - 1)) state_d = FINAL;
      end
      FINAL: begin
        out_d   = shift_rows(sub_bytes(st_q)) ^ rk;
        done_d  = 1'b1;
        rc_d    = 4'd0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      rc_q    <= 4'd0;
      st_q    <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rc_q    <= rc_d;
      st_q    <= st_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end

  assign bus.metin_o = out_q;
  assign bus.bitti_o = done_q;
  assign bus.busy_o  = (state_q != IDLE);

`ifdef AES_START_ERR_EN
  logic err_q, err_d;

  assign err_d = bus.basla_i && (state_q != IDLE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) err_q <= 1'b0;
    else         err_q <= err_d;
  end

  assign bus.err_o = err_q;
`endif
endmodule
